evo_scheduler: RTL
==================

# evo_scheduler

Generation scheduler for the Life environment engine. It turns the speed keys, the run/edit mode bit and the random-fill key into a strictly serialized stream of engine commands (STEP, RANDOM) over a req/done handshake. It owns the generation timer, the speed level and the generation counter shown on the display. It sits between the main control block (key levels, mode) and the environment update engine.

## Interface
- BASE_DIV, 390_625, clk cycles per timer unit (7.8 ms @ 50 MHz)
- SPEED_MAX, 7, highest speed level; level width is 3 bits
- RESET_SPEED, 3, speed level after reset
- clk  in  1  system clock; all inputs are synchronous to it
- rst  in  1  reset, asynchronous, active-low
- mode  in  1  0 = run (timer-driven steps), 1 = edit (timer halted)
- inc_v  in  1  speed-up key level
- dec_v  in  1  slow-down key level
- rand_key  in  1  random-fill key level
- step_key  in  1  single-step key level; honoured only in edit mode
- evo_done  in  1  one-cycle pulse from the engine: current command finished
- evo_req  out  1  command request; held high until evo_done
- evo_cmd  out  2  01 = STEP, 10 = RANDOM; 00 when idle
- speed  out  3  current speed level
- gen_count  out  16  generations stepped since the last RANDOM or reset
- busy  out  1  high while a command is outstanding
- overrun  out  1  sticky: a timer tick was lost while a step was already pending

## Operation
- Key inputs are edge-detected internally with a registered previous value. Only rising edges act.
- Speed:
  - An inc_v edge increments speed, saturating at SPEED_MAX.
  - A dec_v edge decrements speed, saturating at 0.
  - inc and dec edges in the same cycle: no change.
  - Any speed change clears the interval counter.
- Timer:
  - A prescaler counts 0..BASE_DIV-1 and emits a unit tick on wrap.
  - The interval counter counts unit ticks up to period = 1 << (SPEED_MAX - speed). Speed 0 gives 128 units; SPEED_MAX gives 1 unit.
  - Reaching the period emits an expiry and clears the interval counter.
  - Prescaler and interval counter run only while mode = 0. They are held at 0 while mode = 1.
- Pending flags:
  - step_pend is set by a timer expiry (mode 0) or a step_key edge (mode 1).
  - rand_pend is set by a rand_key edge in either mode.
  - Setting a flag that is already set has no further effect, except that a timer expiry with step_pend already set also sets overrun.
- Mode 0→1 transition clears step_pend. An in-flight command still completes.
- FSM IDLE:
  - If rand_pend: issue RANDOM and clear rand_pend.
  - Else if step_pend: issue STEP and clear step_pend.
  - Issuing means evo_req=1 and evo_cmd set; go to BUSY.
  - RANDOM has priority over STEP.
- FSM BUSY:
  - evo_req and evo_cmd are held stable.
  - On evo_done: deassert, go to IDLE.
  - On STEP completion, gen_count increments and wraps 0xFFFF→0.
  - On RANDOM completion, gen_count is cleared to 0.
- evo_done in IDLE is ignored.
- busy equals (state == BUSY).

## Timing
- Reset values:
  - evo_req=0, evo_cmd=00, busy=0, gen_count=0, overrun=0, speed=RESET_SPEED.
  - Internally: state IDLE, all pending flags 0, counters 0, key history 0.
  - An asynchronous reset mid-command aborts it immediately; the engine shares rst.
- Key edge → pending flag set: 1 cycle after the key rises.
- Flag set → evo_req high: 1 cycle (IDLE sees the flag at the next edge).
- Key rise to evo_req high in IDLE: 2 cycles.
- evo_done sampled at edge N → evo_req low and gen_count updated after edge N.
- evo_req stays low for at least one cycle between commands, so back-to-back commands are separated by at least one IDLE cycle.
- Expiry and a step_key edge in the same cycle: one STEP only.
- rand_key edge while BUSY with STEP: RANDOM is issued after that STEP completes, ahead of any STEP pending at that time.

## Test plan
- Reset, speed: with rst low, then released → speed=3, evo_req=0, gen_count=0. Four inc_v pulses → speed=7. Nine dec_v pulses → speed=0.
- Run-mode cadence: BASE_DIV=4, speed=3, mode=0, engine returns evo_done 3 cycles after evo_req rises → STEP requests every 64 cycles; gen_count reaches 5 after 5 periods.
- Edit mode: mode=1 → no timer requests for 1000 cycles. Each step_key pulse gives exactly one STEP and gen_count+1.
- Priority: rand_key and timer expiry pending together in IDLE → RANDOM is issued first, then STEP. gen_count reads 0 after RANDOM done and 1 after STEP done.
- Overrun: speed=7, BASE_DIV=4, engine withholds evo_done for 20 cycles → overrun=1 and stays 1. Exactly one STEP is issued after the first one completes.
- Mid-command reset: assert rst low while evo_req=1 → evo_req=0, busy=0, evo_cmd=00 asynchronously. After release no command is issued without a new edge or expiry.

Source files
------------

// File: rtl/evo_scheduler_if.sv
// evo_scheduler_if: command handshake between the generation scheduler and the update engine
interface evo_scheduler_if;
   logic       evo_req;
   logic [1:0] evo_cmd;
   logic       evo_done;
   modport master (output evo_req, output evo_cmd, input evo_done);
   modport slave  (input evo_req, input evo_cmd, output evo_done);
endinterface

// File: rtl/evo_scheduler.sv
// evo_scheduler: turns speed/mode/random/step keys into serialized STEP and RANDOM engine commands
module evo_scheduler #(
   parameter int BASE_DIV    = 390_625,
   parameter int SPEED_MAX   = 7,
   parameter int RESET_SPEED = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   inc_v,
   input  logic                   dec_v,
   input  logic                   rand_key,
   input  logic                   step_key,
   evo_scheduler_if.master        evo,
   output logic [2:0]             speed,
   output logic [15:0]            gen_count,
   output logic                   busy,
   output logic                   overrun
);
   localparam int PW = BASE_DIV > 1 ? $clog2(BASE_DIV) : 1;
   localparam int IW = SPEED_MAX + 1;
   localparam logic [1:0] CMD_STEP = 2'b01;
   localparam logic [1:0] CMD_RAND = 2'b10;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [2:0]      speed_q, speed_d;
   logic [15:0]     gen_q, gen_d;
   logic            ovr_q, ovr_d;
   logic            step_pend_q, step_pend_d;
   logic            rand_pend_q, rand_pend_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [IW-1:0]   ivl_q, ivl_d;
   logic [4:0]      keys_q, keys_d;
   logic [4:0]      edges;
   logic [IW-1:0]   period;
   logic            tick, expiry;

   // Key edge detection, speed level and the two-stage generation timer
   always_comb begin
      keys_d  = {inc_v, dec_v, rand_key, step_key, mode};
      edges   = keys_d & ~keys_q;
      speed_d = speed_q;
      if (edges[4] && !edges[3] && speed_q != 3'(SPEED_MAX))
         speed_d = speed_q + 3'd1;
      else if (edges[3] && !edges[4] && speed_q != 3'd0)
         speed_d = speed_q - 3'd1;
      period = IW'(1) << (3'(SPEED_MAX) - speed_q);
      tick   = !mode && pre_q == PW'(BASE_DIV - 1);
      expiry = tick && (ivl_q + IW'(1)) == period;
      pre_d  = (mode || tick) ? '0 : pre_q + PW'(1);
      ivl_d  = (mode || speed_d != speed_q || expiry) ? '0 : tick ? ivl_q + IW'(1) : ivl_q;
   end

   // Pending flags and the IDLE/BUSY command sequencer; RANDOM outranks STEP
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      gen_d       = gen_q;
      step_pend_d = step_pend_q;
      rand_pend_d = rand_pend_q;
      if (state_q == IDLE) begin
         if (rand_pend_q) begin
            state_d     = BUSY;
            cmd_d       = CMD_RAND;
            rand_pend_d = 1'b0;
         end else if (step_pend_q) begin
            state_d     = BUSY;
            cmd_d       = CMD_STEP;
            step_pend_d = 1'b0;
         end
      end else if (evo.evo_done) begin
         state_d = IDLE;
         cmd_d   = 2'b00;
         gen_d   = cmd_q == CMD_STEP ? gen_q + 16'd1 : 16'd0;
      end
      // a tick is lost only if the previous step is still waiting after this cycle's issue
      ovr_d = ovr_q | (expiry & step_pend_d);
      if (edges[0]) step_pend_d = 1'b0;
      if (expiry || (mode && edges[1])) step_pend_d = 1'b1;
      if (edges[2]) rand_pend_d = 1'b1;
   end

   // State registers; reset aborts any in-flight command at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cmd_q       <= 2'b00;
         speed_q     <= 3'(RESET_SPEED);
         gen_q       <= '0;
         ovr_q       <= 1'b0;
         step_pend_q <= 1'b0;
         rand_pend_q <= 1'b0;
         pre_q       <= '0;
         ivl_q       <= '0;
         keys_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         speed_q     <= speed_d;
         gen_q       <= gen_d;
         ovr_q       <= ovr_d;
         step_pend_q <= step_pend_d;
         rand_pend_q <= rand_pend_d;
         pre_q       <= pre_d;
         ivl_q       <= ivl_d;
         keys_q      <= keys_d;
      end
   end

   assign evo.evo_req = state_q == BUSY;
   assign evo.evo_cmd = cmd_q;
   assign busy        = state_q == BUSY;
   assign speed       = speed_q;
   assign gen_count   = gen_q;
   assign overrun     = ovr_q;
endmodule
